// File: rtl/bcd_pkg.sv
// Shared types and constants for the multi-digit BCD counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    COMMIT = 2'd2
  } bcd_state_e;

  // Preset digits outside 0..9 are forced to zero.
  function automatic bcd_digit_t bcd_sanitize(bcd_digit_t d);
    return (d > BCD_NINE) ? BCD_ZERO : d;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Single-digit BCD increment stage; a digit above 9 is treated as 9.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t next_digit_c_o,
  output logic       carry_c_o
);

  // Increment with decimal carry.
  always_comb begin
    carry_c_o      = (digit_i >= BCD_NINE);
    next_digit_c_o = carry_c_o ? BCD_ZERO : 4'(digit_i + 4'd1);
  end

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Multi-digit BCD counter controller: prescaler tick, LSD-first ripple walk
// through one shared digit stage, atomic commit with a one-cycle update pulse.
// Optional macro BCD_COUNTER_SATURATE_EN: saturate at all-nines with a sticky
// overflow flag instead of wrapping with an overflow pulse.
module bcd_counter_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  busy,
  output logic                  update,
  output logic                  overflow
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

`ifdef BCD_COUNTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_counter_ctrl: DIGITS must be 1..8");
  end
  if (PRESCALE < DIGITS + 2) begin : g_bad_prescale
    $error("bcd_counter_ctrl: PRESCALE must be >= DIGITS+2");
  end

  logic [PW-1:0]                presc_q;
  logic                         tick_c;
  bcd_state_e                   state_q;
  logic [IW-1:0]                idx_q;
  bcd_digit_t [DIGITS-1:0]      work_q;
  bcd_digit_t [DIGITS-1:0]      digits_q;
  bcd_digit_t [DIGITS-1:0]      work_next_c;
  bcd_digit_t [DIGITS-1:0]      load_clean_c;
  logic                         busy_q;
  logic                         update_q;
  logic                         overflow_q;
  bcd_digit_t                   step_in_c;
  bcd_digit_t                   step_out_c;
  logic                         step_carry_c;
  logic                         skip_c;

  assign tick_c    = run && (presc_q == PW'(PRESCALE - 1));
  assign step_in_c = work_q[idx_q];

  bcd_digit_step u_step (
    .digit_i        (step_in_c),
    .next_digit_c_o (step_out_c),
    .carry_c_o      (step_carry_c)
  );

  // Working copy with the currently addressed digit replaced by the stage result.
  always_comb begin
    work_next_c        = work_q;
    work_next_c[idx_q] = step_out_c;
  end

  // Sanitised preset value.
  always_comb begin
    for (int i = 0; i < int'(DIGITS); i++) begin
      load_clean_c[i] = bcd_sanitize(load_value[4*i +: 4]);
    end
  end

`ifdef BCD_COUNTER_SATURATE_EN
  // Saturating build: an all-nines count bypasses the walk.
  always_comb begin
    skip_c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (digits_q[i] != BCD_NINE) skip_c = 1'b0;
    end
  end
`else
  assign skip_c = 1'b0;
`endif

  // Prescaler: wraps at PRESCALE-1 while running, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (clear || load) begin
      presc_q <= '0;
    end else if (run) begin
      presc_q <= tick_c ? '0 : PW'(presc_q + PW'(1));
    end
  end

  // Walk FSM with registered outputs; clear > load > tick/walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      work_q     <= '0;
      digits_q   <= '0;
      busy_q     <= 1'b0;
      update_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      update_q <= 1'b0;
      if (!SATURATE) overflow_q <= 1'b0;
      if (clear) begin
        state_q    <= IDLE;
        idx_q      <= '0;
        digits_q   <= '0;
        busy_q     <= 1'b0;
        update_q   <= 1'b1;
        overflow_q <= 1'b0;
      end else if (load) begin
        state_q    <= IDLE;
        idx_q      <= '0;
        digits_q   <= load_clean_c;
        busy_q     <= 1'b0;
        update_q   <= 1'b1;
        overflow_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (tick_c) begin
              busy_q <= 1'b1;
              if (skip_c) begin
                state_q    <= COMMIT;
                update_q   <= 1'b1;
                overflow_q <= 1'b1;
              end else begin
                work_q  <= digits_q;
                idx_q   <= '0;
                state_q <= STEP;
              end
            end
          end
          STEP: begin
            work_q <= work_next_c;
            if (step_carry_c && (idx_q != LAST_IDX)) begin
              idx_q <= IW'(idx_q + IW'(1));
            end else begin
              digits_q <= work_next_c;
              update_q <= 1'b1;
              state_q  <= COMMIT;
              if (step_carry_c) overflow_q <= 1'b1;
            end
          end
          COMMIT: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign digits   = digits_q;
  assign busy     = busy_q;
  assign update   = update_q;
  assign overflow = overflow_q;

endmodule
